// File: rtl/dac_spi_tx.sv
// dac_spi_tx: pops one sample per frame from an upstream FIFO and shifts it out MSB-first over SPI mode 0.
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous active-high reset
//   enable            permits new frames to start (sampled only while idle)
//   fifo_dout         registered FIFO sample, valid the cycle after a pop
//   fifo_is_empty     upstream FIFO empty flag
//   fifo_read_request one-cycle pop strobe
//   dac_sclk          serial clock, idle low
//   dac_sdata         serial data, MSB first
//   dac_cs_n          active-low frame select
//   busy              high whenever a frame is in progress
//   frames_sent       wrapping count of completed frames
module dac_spi_tx #(
    parameter int WIDTH  = 8,
    parameter int CLKDIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_is_empty,
    output logic             fifo_read_request,
    output logic             dac_sclk,
    output logic             dac_sdata,
    output logic             dac_cs_n,
    output logic             busy,
    output logic [15:0]      frames_sent
);
    typedef enum logic [2:0] {IDLE, REQ, LOAD, SHIFT, GAP} state_t;
    state_t           state_q;
    logic [7:0]       div_q;
    logic [4:0]       bit_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;
    logic             div_end;
    assign sh_d    = sh_q << 1;
    assign div_end = (div_q == 8'(CLKDIV - 1));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            div_q             <= 8'd0;
            bit_q             <= 5'd0;
            sh_q              <= '0;
            fifo_read_request <= 1'b0;
            dac_sclk          <= 1'b0;
            dac_sdata         <= 1'b0;
            dac_cs_n          <= 1'b1;
            busy              <= 1'b0;
            frames_sent       <= 16'd0;
        end else begin
            case (state_q)
                IDLE: if (enable && !fifo_is_empty) begin
                    state_q           <= REQ;
                    fifo_read_request <= 1'b1;
                    busy              <= 1'b1;
                end
                REQ: begin
                    state_q           <= LOAD;
                    fifo_read_request <= 1'b0;
                end
                LOAD: begin
                    sh_q      <= fifo_dout;
                    dac_sdata <= fifo_dout[WIDTH-1];
                    dac_cs_n  <= 1'b0;
                    div_q     <= 8'd0;
                    bit_q     <= 5'd0;
                    state_q   <= SHIFT;
                end
                SHIFT: begin
                    div_q <= div_end ? 8'd0 : div_q + 8'd1;
                    if (div_end) begin
                        dac_sclk <= !dac_sclk;
                        // sclk currently high means this half-period ends in a falling edge
                        if (dac_sclk) begin
                            if (bit_q == 5'(WIDTH - 1)) begin
                                dac_cs_n    <= 1'b1;
                                dac_sdata   <= 1'b0;
                                frames_sent <= frames_sent + 16'd1;
                                state_q     <= GAP;
                            end else begin
                                bit_q     <= bit_q + 5'd1;
                                sh_q      <= sh_d;
                                dac_sdata <= sh_d[WIDTH-1];
                            end
                        end
                    end
                end
                GAP: begin
                    div_q <= div_end ? 8'd0 : div_q + 8'd1;
                    if (div_end) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q           <= IDLE;
                    fifo_read_request <= 1'b0;
                    dac_sclk          <= 1'b0;
                    dac_sdata         <= 1'b0;
                    dac_cs_n          <= 1'b1;
                    busy              <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: directed bench for dac_spi_tx with a phase-arithmetic reference model.
module tb_dac_spi_tx;
    localparam int W    = 8;
    localparam int C    = 4;
    localparam int SH   = 2 * C * W;
    localparam int FEND = 2 + SH + C;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [W-1:0] fifo_dout = '0;
    logic        fifo_is_empty;
    logic        fifo_read_request, dac_sclk, dac_sdata, dac_cs_n, busy;
    logic [15:0] frames_sent;
    int checks = 0;
    int passed = 0;
    dac_spi_tx #(.WIDTH(W), .CLKDIV(C)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_dout(fifo_dout),
        .fifo_is_empty(fifo_is_empty), .fifo_read_request(fifo_read_request),
        .dac_sclk(dac_sclk), .dac_sdata(dac_sdata), .dac_cs_n(dac_cs_n),
        .busy(busy), .frames_sent(frames_sent)
    );
    initial forever #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask
    // Upstream FIFO: bench writes mem[n_push], FIFO pops mem[n_pop] into a registered dout.
    logic [W-1:0] mem [64];
    int n_push = 0;
    int n_pop = 0;
    assign fifo_is_empty = (n_push == n_pop);
    always @(posedge clk) if (fifo_read_request) begin
        fifo_dout <= mem[n_pop];
        n_pop     <= n_pop + 1;
    end
    task automatic push(input logic [W-1:0] v);
        mem[n_push] = v;
        n_push++;
    endtask
    // Reference model: t counts cycles since the REQ cycle of the current frame.
    int         t = 0;
    bit         inf = 0;
    logic [W-1:0] smp = '0;
    logic [15:0] m_frames = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            inf = 0; t = 0; m_frames = 0;
        end else if (inf) begin
            t++;
            if (t == 2 + SH) m_frames++;
            if (t == FEND) inf = 0;
        end else if (enable && !fifo_is_empty) begin
            inf = 1; t = 0; smp = mem[n_pop];
        end
    end
    function automatic logic [20:0] model_out();
        bit sh;
        int s;
        logic e_sclk, e_sd;
        sh = inf && t >= 2 && t < 2 + SH;
        s = t - 2;
        e_sclk = sh ? logic'((s / C) % 2) : 1'b0;
        e_sd = sh ? smp[W - 1 - s / (2 * C)] : 1'b0;
        return {logic'(inf && t == 0), e_sclk, e_sd, logic'(!sh), logic'(inf), m_frames};
    endfunction
    always @(negedge clk)
        check("cycle", {11'd0, fifo_read_request, dac_sclk, dac_sdata, dac_cs_n, busy, frames_sent},
              {11'd0, model_out()});
    // Monitors
    int cyc = 0, pops = 0, rises = 0, cs_low = 0, hi_run = 0;
    bit seen_low = 0;
    logic [15:0] bits = 0;
    int pop_cyc[$];
    int gaps[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (fifo_read_request) begin pops++; pop_cyc.push_back(cyc); end
        if (dac_cs_n) hi_run++;
        else begin
            if (seen_low && hi_run > 0) gaps.push_back(hi_run);
            hi_run = 0; seen_low = 1; cs_low++;
        end
    end
    always @(posedge dac_sclk) begin bits = {bits[14:0], dac_sdata}; rises++; end
    task automatic wait_frames(input logic [15:0] target, input int bound);
        int n = 0;
        while (frames_sent != target && n < bound) begin @(negedge clk); n++; end
        check("frames_reached", frames_sent, target);
    endtask
    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin @(negedge clk); n++; end
        check("idle_reached", busy, 0);
    endtask
    task automatic wait_pop(input int bound);
        int n = 0;
        while (!fifo_read_request && n < bound) begin @(negedge clk); n++; end
        check("pop_seen", fifo_read_request, 1);
    endtask
    initial begin
        int p0, r0, c0, k0, g0;
        logic [15:0] f0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", dac_cs_n, 1);
        check("rst_busy", busy, 0);
        check("rst_frames", frames_sent, 0);
        reset = 1'b0;
        // single word 0xA5
        p0 = pops; r0 = rises; c0 = cs_low;
        push(8'hA5);
        enable = 1'b1;
        wait_frames(16'd1, 200);
        wait_idle(50);
        check("a5_pops", pops - p0, 1);
        check("a5_cs_low", cs_low - c0, 64);
        check("a5_rises", rises - r0, 8);
        check("a5_bits", bits[7:0], 8'hA5);
        // three back-to-back words
        p0 = pops; k0 = pop_cyc.size(); g0 = gaps.size(); f0 = frames_sent;
        push(8'h00); push(8'hFF); push(8'h3C);
        wait_frames(f0 + 16'd3, 400);
        wait_idle(50);
        check("b2b_pops", pops - p0, 3);
        check("b2b_space1", pop_cyc[k0 + 1] - pop_cyc[k0], 71);
        check("b2b_space2", pop_cyc[k0 + 2] - pop_cyc[k0 + 1], 71);
        check("b2b_gaps", gaps.size() - g0, 3);
        for (int i = g0; i < gaps.size(); i++) check("b2b_cs_gap", gaps[i] >= 4, 1);
        check("b2b_last", bits[7:0], 8'h3C);
        // empty FIFO with enable high
        p0 = pops; c0 = cs_low; k0 = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) k0++;
        end
        check("empty_pops", pops - p0, 0);
        check("empty_busy", k0, 0);
        check("empty_cs_low", cs_low - c0, 0);
        // enable dropped during bit 3
        enable = 1'b0;
        push(8'h5A); push(8'h77);
        p0 = pops; r0 = rises; f0 = frames_sent;
        enable = 1'b1;
        wait_pop(20);
        repeat (27) @(negedge clk);
        enable = 1'b0;
        wait_frames(f0 + 16'd1, 200);
        wait_idle(50);
        repeat (100) @(negedge clk);
        check("en_rises", rises - r0, 8);
        check("en_bits", bits[7:0], 8'h5A);
        check("en_pops", pops - p0, 1);
        check("en_frames", frames_sent, f0 + 16'd1);
        check("en_fifo_left", n_push - n_pop, 1);
        // reset during bit 5
        enable = 1'b1;
        wait_pop(20);
        repeat (44) @(negedge clk);
        check("mid_cs_low", dac_cs_n, 0);
        #2 reset = 1'b1;
        #1;
        check("ar_cs_n", dac_cs_n, 1);
        check("ar_sclk", dac_sclk, 0);
        check("ar_sdata", dac_sdata, 0);
        check("ar_busy", busy, 0);
        check("ar_req", fifo_read_request, 0);
        check("ar_frames", frames_sent, 0);
        push(8'hC3);
        @(negedge clk);
        p0 = pops; r0 = rises; c0 = cs_low;
        reset = 1'b0;
        wait_frames(16'd1, 200);
        wait_idle(50);
        check("post_pops", pops - p0, 1);
        check("post_rises", rises - r0, 8);
        check("post_bits", bits[7:0], 8'hC3);
        check("post_cs_low", cs_low - c0, 64);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
